// File: rtl/ex_cs_sub90_pipe.sv
// Two-stage pipelined 90-bit carry-select subtractor: valC = {cout, A - B - bin}, valCi = ~valC.
// Optional compare flags are built only when EXCSSUB90_FLAGS_EN is defined; otherwise the flag ports read 0.
module ex_cs_sub90_pipe (
    input  logic        clock,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic [89:0] valA,
    input  logic [89:0] valB,
    input  logic        bin,
    output logic        outValid,
    input  logic        outReady,
    output logic [90:0] valC,
    output logic [90:0] valCi,
    output logic        flagZ,
    output logic        flagN,
    output logic        flagULT,
    output logic        flagSLT,
    output logic        flagV
);

    localparam int NCH = 6;

    logic        vld_p1;
    logic        vld_p2;
    logic        accept;
    logic        s2_adv;

    logic [89:0] sum0_c, sum1_c;
    logic [NCH-1:0] co0_c, co1_c;

    logic [89:0] sum0_p1, sum1_p1;
    logic [NCH-1:0] co0_p1, co1_p1;
    logic        cin_p1;

    logic [NCH:0] carry_c;
    logic [89:0] diff_c;

    assign s2_adv   = vld_p1 & (~vld_p2 | outReady);
    assign inReady  = ~vld_p1 | s2_adv;
    assign accept   = inValid & inReady;
    assign outValid = vld_p2;

    // Both chunk candidates (carry-in 0 and 1) are formed per chunk; chunk 5 is 10 bits wide.
    for (genvar k = 0; k < NCH; k++) begin : g_chunk
        localparam int LO = k * 16;
        localparam int CW = (k < NCH - 1) ? 16 : 10;
        logic [CW:0] s0, s1;
        assign s0 = {1'b0, valA[LO +: CW]} + {1'b0, ~valB[LO +: CW]};
        assign s1 = s0 + {{CW{1'b0}}, 1'b1};
        assign sum0_c[LO +: CW] = s0[CW-1:0];
        assign sum1_c[LO +: CW] = s1[CW-1:0];
        assign co0_c[k] = s0[CW];
        assign co1_c[k] = s1[CW];
    end

    // ---- stage 1 boundary: chunk sums registered ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (s2_adv) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            sum0_p1 <= sum0_c;
            sum1_p1 <= sum1_c;
            co0_p1  <= co0_c;
            co1_p1  <= co1_c;
            cin_p1  <= ~bin;
        end
    end

    // Carry ripples only through the six chunk selects, not through 90 bits.
    always_comb begin
        carry_c = '0;
        diff_c  = '0;
        carry_c[0] = cin_p1;
        for (int k = 0; k < NCH; k++) begin
            carry_c[k+1] = carry_c[k] ? co1_p1[k] : co0_p1[k];
        end
        for (int k = 0; k < NCH - 1; k++) begin
            diff_c[k*16 +: 16] = carry_c[k] ? sum1_p1[k*16 +: 16] : sum0_p1[k*16 +: 16];
        end
        diff_c[89:80] = carry_c[NCH-1] ? sum1_p1[89:80] : sum0_p1[89:80];
    end

    // ---- stage 2 boundary: result and inverse registered ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p2 <= 1'b0;
            valC   <= '0;
            valCi  <= '1;
        end else begin
            if (s2_adv) begin
                vld_p2 <= 1'b1;
                valC   <= {carry_c[NCH], diff_c};
                valCi  <= ~{carry_c[NCH], diff_c};
            end else if (outReady) begin
                vld_p2 <= 1'b0;
            end
        end
    end

`ifdef EXCSSUB90_FLAGS_EN
    logic a89_p1, nb89_p1;
    logic ovf_c;

    always_ff @(posedge clock) begin
        if (accept) begin
            a89_p1  <= valA[89];
            nb89_p1 <= ~valB[89];
        end
    end

    // Overflow: operands of A + ~B agree in sign but the result sign differs from A.
    assign ovf_c = (a89_p1 == nb89_p1) & (diff_c[89] != a89_p1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flagZ   <= 1'b0;
            flagN   <= 1'b0;
            flagULT <= 1'b0;
            flagSLT <= 1'b0;
            flagV   <= 1'b0;
        end else if (s2_adv) begin
            flagZ   <= ~|diff_c;
            flagN   <= diff_c[89];
            flagULT <= ~carry_c[NCH];
            flagSLT <= diff_c[89] ^ ovf_c;
            flagV   <= ovf_c;
        end
    end
`else
    assign flagZ   = 1'b0;
    assign flagN   = 1'b0;
    assign flagULT = 1'b0;
    assign flagSLT = 1'b0;
    assign flagV   = 1'b0;
`endif

endmodule
